// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// IF does a zero-latency lookup; MEM trains the table with the resolved outcome.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] IFpc,
  output logic        PRtaken,
  output logic [31:0] PRtarget,
  input  logic        MMupdate,
  input  logic [31:0] MMpc,
  input  logic [31:0] MMtarget,
  input  logic        MMtaken,
  input  logic        MMpredicted,
  output logic        MMmiss,
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic            valid  [ENTRIES];
  logic [TAGW-1:0] tag    [ENTRIES];
  logic [31:0]     target [ENTRIES];
  logic [1:0]      ctr    [ENTRIES];

  logic [IDXW-1:0] ifidx;
  logic [TAGW-1:0] iftag;
  logic [IDXW-1:0] mmidx;
  logic [TAGW-1:0] mmtag;
  logic            hit;
  logic            mhit;
  logic            unused_lowbits;

  assign ifidx = IFpc[IDXW+1:2];
  assign iftag = IFpc[31:IDXW+2];
  assign mmidx = MMpc[IDXW+1:2];
  assign mmtag = MMpc[31:IDXW+2];
  assign unused_lowbits = ^{IFpc[1:0], MMpc[1:0]};

  assign hit      = valid[ifidx] && (tag[ifidx] == iftag);
  assign mhit     = valid[mmidx] && (tag[mmidx] == mmtag);
  assign PRtaken  = hit && ctr[ifidx][1];
  assign PRtarget = PRtaken ? target[ifidx] : IFpc + 32'd4;
  assign MMmiss   = MMupdate && (MMpredicted != MMtaken);

  // A not-taken miss never allocates, so an aliased entry survives it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < ENTRIES; k++) begin
        valid[k]  <= 1'b0;
        tag[k]    <= '0;
        target[k] <= '0;
        ctr[k]    <= 2'b01;
      end
    end else if (MMupdate) begin
      if (mhit) begin
        if (MMtaken) begin
          if (ctr[mmidx] != 2'b11) ctr[mmidx] <= ctr[mmidx] + 2'b01;
          target[mmidx] <= MMtarget;
        end else if (ctr[mmidx] != 2'b00) begin
          ctr[mmidx] <= ctr[mmidx] - 2'b01;
        end
      end else if (MMtaken) begin
        valid[mmidx]  <= 1'b1;
        tag[mmidx]    <= mmtag;
        target[mmidx] <= MMtarget;
        ctr[mmidx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitcnt  <= '0;
      misscnt <= '0;
    end else begin
      if (hit && (hitcnt != 32'hFFFFFFFF)) hitcnt <= hitcnt + 32'd1;
      if (MMmiss && (misscnt != 32'hFFFFFFFF)) misscnt <= misscnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: an abstract table model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [31:0] IFpc = '0;
  logic        PRtaken;
  logic [31:0] PRtarget;
  logic        MMupdate = 1'b0;
  logic [31:0] MMpc = '0;
  logic [31:0] MMtarget = '0;
  logic        MMtaken = 1'b0;
  logic        MMpredicted = 1'b0;
  logic        MMmiss;
  logic [31:0] hitcnt;
  logic [31:0] misscnt;

  int total = 0;
  int bad = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK(CLK), .nRST(nRST), .IFpc(IFpc), .PRtaken(PRtaken), .PRtarget(PRtarget),
    .MMupdate(MMupdate), .MMpc(MMpc), .MMtarget(MMtarget), .MMtaken(MMtaken),
    .MMpredicted(MMpredicted), .MMmiss(MMmiss), .hitcnt(hitcnt), .misscnt(misscnt)
  );

  always #5 CLK = ~CLK;

  // Model: entry = pc/4 mod 16, tag = pc/64, counter is an int in 0..3.
  bit          mvalid [16];
  logic [31:0] mtag   [16];
  logic [31:0] mtgt   [16];
  int          mctr   [16];
  logic [31:0] mhits;
  logic [31:0] mmisses;

  function automatic int eidx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] etag(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit modelHit(input logic [31:0] pc);
    return mvalid[eidx(pc)] && (mtag[eidx(pc)] == etag(pc));
  endfunction

  function automatic bit modelTaken(input logic [31:0] pc);
    return modelHit(pc) && (mctr[eidx(pc)] >= 2);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < 16; k++) begin
        mvalid[k] = 0; mtag[k] = '0; mtgt[k] = '0; mctr[k] = 1;
      end
      mhits = '0;
      mmisses = '0;
    end else begin
      if (modelHit(IFpc) && mhits != 32'hFFFFFFFF) mhits = mhits + 1;
      if (MMupdate && (MMpredicted != MMtaken) && mmisses != 32'hFFFFFFFF) mmisses = mmisses + 1;
      if (MMupdate) begin
        if (modelHit(MMpc)) begin
          if (MMtaken) begin
            mctr[eidx(MMpc)] = (mctr[eidx(MMpc)] == 3) ? 3 : mctr[eidx(MMpc)] + 1;
            mtgt[eidx(MMpc)] = MMtarget;
          end else begin
            mctr[eidx(MMpc)] = (mctr[eidx(MMpc)] == 0) ? 0 : mctr[eidx(MMpc)] - 1;
          end
        end else if (MMtaken) begin
          mvalid[eidx(MMpc)] = 1;
          mtag[eidx(MMpc)]   = etag(MMpc);
          mtgt[eidx(MMpc)]   = MMtarget;
          mctr[eidx(MMpc)]   = 2;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLK) begin
    checkOutput("model PRtaken", {31'd0, PRtaken}, {31'd0, modelTaken(IFpc)});
    checkOutput("model PRtarget", PRtarget, modelTaken(IFpc) ? mtgt[eidx(IFpc)] : IFpc + 32'd4);
    checkOutput("model MMmiss", {31'd0, MMmiss}, {31'd0, MMupdate && (MMpredicted != MMtaken)});
    checkOutput("model hitcnt", hitcnt, mhits);
    checkOutput("model misscnt", misscnt, mmisses);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ifpc, input logic upd, input logic [31:0] mpc,
                               input logic [31:0] mtarget, input logic mtaken, input logic mpred);
    IFpc = ifpc; MMupdate = upd; MMpc = mpc; MMtarget = mtarget;
    MMtaken = mtaken; MMpredicted = mpred;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken, input logic pred);
    applyStimulus(pc, 1'b1, pc, tgt, taken, pred);
    tick();
    applyStimulus(pc, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    #1 nRST = 1'b0;
    #11 nRST = 1'b1;

    // 1: empty table
    applyStimulus(32'h40, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("t1 PRtaken", {31'd0, PRtaken}, 32'd0);
    checkOutput("t1 PRtarget", PRtarget, 32'h44);
    checkOutput("t1 hitcnt", hitcnt, 32'd0);

    // 2: first taken branch allocates at weakly-taken
    applyStimulus(32'h40, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
    #1;
    checkOutput("t2 MMmiss", {31'd0, MMmiss}, 32'd1);
    tick();
    applyStimulus(32'h40, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("t2 PRtaken", {31'd0, PRtaken}, 32'd1);
    checkOutput("t2 PRtarget", PRtarget, 32'h80);
    checkOutput("t2 misscnt", misscnt, 32'd1);

    // 3: saturate up, then walk down
    train(32'h40, 32'h80, 1'b1, 1'b1);
    train(32'h40, 32'h80, 1'b1, 1'b1);
    train(32'h40, 32'h80, 1'b0, 1'b1);
    checkOutput("t3 after 1 nt", {31'd0, PRtaken}, 32'd1);
    train(32'h40, 32'h80, 1'b0, 1'b1);
    checkOutput("t3 after 2 nt", {31'd0, PRtaken}, 32'd0);
    train(32'h40, 32'h80, 1'b0, 1'b0);
    checkOutput("t3 PRtaken", {31'd0, PRtaken}, 32'd0);
    checkOutput("t3 PRtarget", PRtarget, 32'h44);

    // 4: aliasing between 0x40 and 0x80
    train(32'h40, 32'h80, 1'b1, 1'b0);
    train(32'h40, 32'h80, 1'b1, 1'b0);
    checkOutput("t4 trained", PRtarget, 32'h80);
    train(32'h80, 32'h100, 1'b0, 1'b0);
    IFpc = 32'h40;
    #1;
    checkOutput("t4 alias nt PRtaken", {31'd0, PRtaken}, 32'd1);
    checkOutput("t4 alias nt PRtarget", PRtarget, 32'h80);
    train(32'h80, 32'h100, 1'b1, 1'b0);
    IFpc = 32'h40;
    #1;
    checkOutput("t4 replaced PRtaken", {31'd0, PRtaken}, 32'd0);
    checkOutput("t4 replaced PRtarget", PRtarget, 32'h44);
    IFpc = 32'h80;
    #1;
    checkOutput("t4 new PRtarget", PRtarget, 32'h100);

    // 5: same-cycle lookup and update of a weakly-not-taken entry
    train(32'h44, 32'h200, 1'b1, 1'b0);
    train(32'h44, 32'h200, 1'b0, 1'b1);
    applyStimulus(32'h44, 1'b1, 32'h44, 32'h200, 1'b1, 1'b0);
    #1;
    checkOutput("t5 same cycle", {31'd0, PRtaken}, 32'd0);
    tick();
    applyStimulus(32'h44, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("t5 next cycle", {31'd0, PRtaken}, 32'd1);
    checkOutput("t5 PRtarget", PRtarget, 32'h200);

    // 6: misscnt saturation, then async reset during an update
    tick();
    force dut.misscnt = 32'hFFFFFFFE;
    mmisses = 32'hFFFFFFFE;
    #1 release dut.misscnt;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(32'h80, 1'b1, 32'h48, 32'h300, 1'b0, 1'b1);
      tick();
      if (n == 0) checkOutput("t6 first", misscnt, 32'hFFFFFFFF);
    end
    checkOutput("t6 saturated", misscnt, 32'hFFFFFFFF);
    applyStimulus(32'h80, 1'b1, 32'h80, 32'h400, 1'b1, 1'b0);
    #2 nRST = 1'b0;
    #1;
    checkOutput("t6 rst PRtaken", {31'd0, PRtaken}, 32'd0);
    checkOutput("t6 rst PRtarget", PRtarget, 32'h84);
    checkOutput("t6 rst hitcnt", hitcnt, 32'd0);
    checkOutput("t6 rst misscnt", misscnt, 32'd0);
    tick();
    nRST = 1'b1;
    applyStimulus(32'h80, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("t6 dropped update", {31'd0, PRtaken}, 32'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
